// File: rtl/calc_dec.sv
// Multi-cycle accumulator calculator: accepts an encoded ALU op, executes it
// against the accumulator and writes back three cycles per operation.
module calc_dec #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    input  logic [ACC_W-1:0] operand,
    output logic             op_ready,
    output logic [ACC_W-1:0] acc,
    output logic             res_valid,
    output logic             illegal,
    output logic             zero
);

    localparam int SH_W = $clog2(ACC_W);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t            state;
    logic [3:0]        code_q;
    logic [ACC_W-1:0]  b_q;
    logic [ACC_W-1:0]  result;
    logic              res_ill;
    logic [SH_W-1:0]   sh;

    assign zero = (acc == '0);
    assign sh   = b_q[SH_W-1:0];

    // Illegal codes fall through with result = acc so writeback is uniform.
    always_comb begin
        result  = acc;
        res_ill = 1'b0;
        case (code_q)
            4'b0000: result = acc & b_q;
            4'b0001: result = acc | b_q;
            4'b0010: result = acc + b_q;
            4'b0110: result = acc - b_q;
            4'b0111: result = {{(ACC_W-1){1'b0}}, ($signed(acc) < $signed(b_q))};
            4'b1000: result = acc >> sh;
            4'b1001: result = acc << sh;
            4'b1010: result = ACC_W'($signed(acc) >>> sh);
            4'b1101: result = acc ^ b_q;
            default: res_ill = 1'b1;
        endcase
    end

    // The result registered on leaving EXEC lands directly in acc, so acc and
    // res_valid are both visible during the WB cycle (accept + 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            acc       <= '0;
            res_valid <= 1'b0;
            illegal   <= 1'b0;
            code_q    <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    res_valid <= 1'b0;
                    if (op_valid) begin
                        code_q   <= op_code;
                        b_q      <= operand;
                        op_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    acc       <= result;
                    illegal   <= res_ill;
                    res_valid <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_dec.sv
// Directed scoreboard bench for calc_dec: expected results are queued at
// accept time and compared when res_valid pulses.
module tb_calc_dec;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [15:0] operand;
    logic        op_ready;
    logic [15:0] acc;
    logic        res_valid;
    logic        illegal;
    logic        zero;

    typedef struct {
        logic [15:0] acc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    calc_dec #(.ACC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .operand   (operand),
        .op_ready  (op_ready),
        .acc       (acc),
        .res_valid (res_valid),
        .illegal   (illegal),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare a res_valid cycle against the head of the scoreboard.
    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_acc"}, 32'(acc), 32'(e.acc));
            check({tag, "_ill"}, 32'(illegal), 32'(e.ill));
            check({tag, "_zero"}, 32'(zero), 32'(e.acc == 16'h0000));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (op_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(op_ready), 32'd1);
    endtask

    // Called at a negedge; accept happens on the following posedge (cycle N).
    task automatic run_op(input string tag, input logic [3:0] code, input logic [15:0] b,
                          input logic [15:0] exp_acc, input logic exp_ill);
        exp_t e;
        wait_ready(tag);
        op_valid = 1'b1;
        op_code  = code;
        operand  = b;
        e.acc = exp_acc;
        e.ill = exp_ill;
        sb.push_back(e);
        @(negedge clk);                        // N+1: EXEC
        op_valid = 1'b0;
        op_code  = 4'($urandom);
        operand  = 16'($urandom);
        check({tag, "_rv_n1"}, 32'(res_valid), 32'd0);
        check({tag, "_rdy_n1"}, 32'(op_ready), 32'd0);
        @(negedge clk);                        // N+2: WB
        check({tag, "_rv_n2"}, 32'(res_valid), 32'd1);
        if (res_valid === 1'b1) pop_check(tag);
        @(negedge clk);                        // N+3: IDLE again
        check({tag, "_rv_n3"}, 32'(res_valid), 32'd0);
        check({tag, "_rdy_n3"}, 32'(op_ready), 32'd1);
        check({tag, "_ill_hold"}, 32'(illegal), 32'(exp_ill));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int accepts;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'h0;
        operand  = 16'h0000;

        do_reset();
        check("rst_acc", 32'(acc), 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ill", 32'(illegal), 32'd0);
        check("rst_rv", 32'(res_valid), 32'd0);
        check("rst_rdy", 32'(op_ready), 32'd1);

        run_op("add5",   4'b0010, 16'h0005, 16'h0005, 1'b0);
        run_op("sub7",   4'b0110, 16'h0007, 16'hFFFE, 1'b0);
        run_op("slt0",   4'b0111, 16'h0000, 16'h0001, 1'b0);
        run_op("lsl15",  4'b1001, 16'h000F, 16'h8000, 1'b0);
        run_op("asr13",  4'b1010, 16'h0013, 16'hF000, 1'b0);
        run_op("lsr4",   4'b1000, 16'h0004, 16'h0F00, 1'b0);
        run_op("and0",   4'b0000, 16'h0000, 16'h0000, 1'b0);
        run_op("or1234", 4'b0001, 16'h1234, 16'h1234, 1'b0);
        run_op("ill3",   4'b0011, 16'hABCD, 16'h1234, 1'b1);
        run_op("andff",  4'b0000, 16'hFFFF, 16'h1234, 1'b0);
        run_op("xor",    4'b1101, 16'h00FF, 16'h12CB, 1'b0);
        run_op("lsl0",   4'b1001, 16'h0010, 16'h12CB, 1'b0);
        run_op("addwrap",4'b0010, 16'hFFFF, 16'h12CA, 1'b0);
        run_op("sltneg", 4'b0111, 16'h8000, 16'h0000, 1'b0);
        run_op("ill15",  4'b1111, 16'h0001, 16'h0000, 1'b1);

        // op_valid held for 6 cycles: accepts only in cycles 0 and 3
        do_reset();
        accepts  = 0;
        op_valid = 1'b1;
        op_code  = 4'b0010;
        operand  = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            check($sformatf("thr_rdy%0d", i), 32'(op_ready), 32'((i % 3) == 0));
            check($sformatf("thr_rv%0d", i), 32'(res_valid), 32'((i % 3) == 2));
            if (res_valid === 1'b1) pop_check($sformatf("thr%0d", i));
            if (op_ready === 1'b1) begin
                accepts++;
                e.acc = 16'(accepts);
                e.ill = 1'b0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        check("thr_accepts", 32'(accepts), 32'd2);
        check("thr_acc", 32'(acc), 32'h0002);

        // reset during EXEC aborts the operation
        wait_ready("rstexec");
        op_valid = 1'b1;
        op_code  = 4'b0010;
        operand  = 16'h00FF;
        @(negedge clk);
        op_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstexec_rv", 32'(res_valid), 32'd0);
        check("rstexec_acc", 32'(acc), 32'h0000);
        check("rstexec_rdy", 32'(op_ready), 32'd1);
        @(negedge clk);
        check("rstexec_rv2", 32'(res_valid), 32'd0);
        check("rstexec_acc2", 32'(acc), 32'h0000);

        // reset together with op_valid: no accept
        rst      = 1'b1;
        op_valid = 1'b1;
        op_code  = 4'b0010;
        operand  = 16'h0033;
        @(negedge clk);
        rst      = 1'b0;
        op_valid = 1'b0;
        check("rstvld_rdy", 32'(op_ready), 32'd1);
        @(negedge clk);
        check("rstvld_rdy2", 32'(op_ready), 32'd1);
        @(negedge clk);
        check("rstvld_rv", 32'(res_valid), 32'd0);
        check("rstvld_acc", 32'(acc), 32'h0000);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_dec.md
CALC_DEC -- requirements
Module: calc_dec

Interface
REQ-001 The module SHALL have the parameter ACC_W, default 16, giving the accumulator and operand width in bits; all other widths in this spec assume the default.
REQ-002 The module SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port op_valid  input  1  an encoded operation is presented.
REQ-005 The module SHALL have port op_code  input  4  encoded ALU operation, the calculator button-encoder output format.
REQ-006 The module SHALL have port operand  input  ACC_W  second operand, switch value.
REQ-007 The module SHALL have port op_ready  output  1  the module can accept an operation this cycle.
REQ-008 The module SHALL have port acc  output  ACC_W  accumulator value, driven to the LEDs.
REQ-009 The module SHALL have port res_valid  output  1  one-cycle pulse when an operation completes.
REQ-010 The module SHALL have port illegal  output  1  the last completed operation had an undefined code.
REQ-011 The module SHALL have port zero  output  1  acc == 0, combinational from the acc register.

Function
REQ-012 The module SHALL implement the FSM states IDLE, EXEC and WB with transitions IDLE->EXEC on accept, EXEC->WB unconditionally, and WB->IDLE unconditionally.
REQ-013 op_ready SHALL be 1 only in IDLE; an accept occurs on a cycle where op_valid && op_ready.
REQ-014 On accept, the module SHALL latch op_code and operand into internal registers; later input changes SHALL NOT affect that operation.
REQ-015 op_valid while not in IDLE SHALL be ignored, with no queuing and no error.
REQ-016 EXEC SHALL register the decoded result; WB SHALL write acc and set res_valid=1 for exactly that cycle.
REQ-017 Latency: for an accept in cycle N, acc and res_valid SHALL update in cycle N+2 and op_ready SHALL be 1 again in cycle N+3; maximum throughput is one operation per 3 cycles.
REQ-018 The decode table, with A=acc and B=latched operand, SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A-B); 0111 SLT (1 if A<B signed, else 0); 1000 LSR A>>B[3:0]; 1001 LSL A<<B[3:0]; 1010 ASR A>>>B[3:0] with sign fill; 1101 XOR.
REQ-019 ADD and SUB SHALL wrap modulo 2^ACC_W, with no carry or overflow output.
REQ-020 Shift amounts SHALL use B[$clog2(ACC_W)-1:0] only; upper bits of B are ignored, and a shift of 0 leaves A unchanged.
REQ-021 All other op_code values SHALL be illegal: acc unchanged, illegal=1 in WB, and res_valid still pulsed.
REQ-022 illegal SHALL update only in WB: 1 for an illegal code and 0 for a legal one; it holds between operations.
REQ-023 acc SHALL change only in WB or on reset.

Reset
REQ-024 While rst=1 at a clock edge, the module SHALL go to state IDLE with acc=0, res_valid=0, illegal=0 and latched registers=0; zero SHALL then read 1 and op_ready SHALL read 1 from the following cycle.
REQ-025 Reset in EXEC or WB SHALL abort the operation: no res_valid pulse and acc=0.
REQ-026 rst together with op_valid SHALL cause no accept; reset wins.

Verification
REQ-027 The bench SHALL cover: reset, then op_valid=1, op_code=0010, operand=0x0005 -> res_valid at accept+2, acc=0x0005, zero=0, illegal=0.
REQ-028 The bench SHALL cover: acc=0x0005, SUB with operand 0x0007 -> acc=0xFFFE; then SLT with operand 0x0000 -> acc=0x0001.
REQ-029 The bench SHALL cover: acc=0x8000, ASR with operand 0x0013 -> shift 3, acc=0xF000; then LSR with operand 0x0004 -> acc=0x0F00.
REQ-030 The bench SHALL cover: op_code=0011 with acc=0x1234 -> res_valid pulses, acc stays 0x1234, illegal=1; then a legal AND with operand 0xFFFF -> illegal=0, acc=0x1234.
REQ-031 The bench SHALL cover: op_valid held high for 6 cycles with ADD of 0x0001 from acc=0 -> exactly 2 accepts, at cycles 0 and 3, and acc=0x0002.
REQ-032 The bench SHALL cover: rst asserted in the EXEC cycle of ADD 0x00FF -> no res_valid, acc=0x0000, op_ready=1 on the next cycle.
